// File: rtl/dac_arb_pkg.sv
// dac_arb_pkg: shared types and constants for the TCXO tuning-DAC arbiter.
//   state_t   : overall write sequence IDLE -> LOAD -> SYNC -> SHIFT -> GAP
//   req_idx_t : requester encoding, listed in priority order (DFLT highest)
//   make_frame: builds the 24-bit AD5662 word {6'b0, PD, code}
package dac_arb_pkg;

  localparam int          FRAME_BITS   = 24;
  localparam logic [15:0] DAC_MIDSCALE = 16'd32767;
  localparam logic [1:0]  PD_NORMAL    = 2'b00;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SYNC  = 3'd2,
    SHIFT = 3'd3,
    GAP   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    DFLT = 2'd0,
    HOST = 2'd1,
    LOOP = 2'd2
  } req_idx_t;

  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [15:0] code);
    return {6'b000000, PD_NORMAL, code};
  endfunction

endpackage

// File: rtl/dac_spi_frame_tx.sv
// dac_spi_frame_tx: shifts one AD5662 frame out and enforces the sync_n gap.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : one-cycle request, accepted only when idle; dat is captured then
//   dat[15:0]    : DAC code to send
//   done         : one-cycle pulse in the last GAP cycle (shifter is free next cycle)
//   shifted      : one-cycle pulse in the cycle before sync_n rises (frame complete)
//   sclk,mosi,sync_n : AD5662 serial pins, all registered
//   state_dbg    : current shifter state (IDLE/SYNC/SHIFT/GAP encodings of state_t)
// Sequence: SYNC holds sync_n low with sclk high for SCLK_DIV cycles, then each of
// the 24 bits gets SCLK_DIV cycles of sclk low (DAC samples on the falling edge)
// followed by SCLK_DIV cycles high; mosi moves to the next bit on the rising edge.
module dac_spi_frame_tx
  import dac_arb_pkg::*;
#(
  parameter int SCLK_DIV = 4,
  parameter int MIN_GAP  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] dat,
  output logic        done,
  output logic        shifted,
  output logic        sclk,
  output logic        mosi,
  output logic        sync_n,
  output logic [2:0]  state_dbg
);

  localparam int CNT_MAX = (SCLK_DIV > MIN_GAP) ? SCLK_DIV : MIN_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] LD_HALF = CW'(SCLK_DIV - 1);
  localparam logic [CW-1:0] LD_GAP  = CW'(MIN_GAP - 1);

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [4:0]            bit_cnt, bit_cnt_n;
  logic [FRAME_BITS-1:0] sh, sh_n;
  logic [FRAME_BITS-1:0] frame;
  logic                  sclk_q, sclk_n;
  logic                  mosi_q, mosi_n;
  logic                  sync_n_q, sync_n_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      sclk_q   <= 1'b1;
      mosi_q   <= 1'b0;
      sync_n_q <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_cnt  <= bit_cnt_n;
      sh       <= sh_n;
      sclk_q   <= sclk_n;
      mosi_q   <= mosi_n;
      sync_n_q <= sync_n_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    sh_n      = sh;
    sclk_n    = sclk_q;
    mosi_n    = mosi_q;
    sync_n_n  = sync_n_q;
    done      = 1'b0;
    shifted   = 1'b0;
    frame     = make_frame(dat);

    case (state)
      IDLE: begin
        if (start) begin
          state_n   = SYNC;
          sh_n      = frame;
          mosi_n    = frame[FRAME_BITS-1];
          sync_n_n  = 1'b0;
          sclk_n    = 1'b1;
          cnt_n     = LD_HALF;
          bit_cnt_n = 5'(FRAME_BITS - 1);
        end
      end

      SYNC: begin
        if (cnt == '0) begin
          state_n = SHIFT;
          sclk_n  = 1'b0;
          cnt_n   = LD_HALF;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      SHIFT: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (!sclk_q) begin
          // end of low phase: rising edge, present the next bit
          sclk_n = 1'b1;
          cnt_n  = LD_HALF;
          sh_n   = {sh[FRAME_BITS-2:0], 1'b0};
          mosi_n = sh[FRAME_BITS-2];
        end else if (bit_cnt == '0) begin
          // end of high phase of the last bit: frame is complete
          state_n  = GAP;
          sync_n_n = 1'b1;
          mosi_n   = 1'b0;
          cnt_n    = LD_GAP;
          shifted  = 1'b1;
        end else begin
          bit_cnt_n = bit_cnt - 1'b1;
          sclk_n    = 1'b0;
          cnt_n     = LD_HALF;
        end
      end

      GAP: begin
        if (cnt == '0) begin
          state_n = IDLE;
          done    = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign sync_n    = sync_n_q;
  assign state_dbg = state;

endmodule

// File: rtl/tcxo_dac_arbiter.sv
// tcxo_dac_arbiter: shares the AD5662 TCXO tuning DAC between a default/holdover
// load, a host write path and the PPS disciplining loop.
//   clk, reset_n        : clock, asynchronous active-low reset
//   dflt_load, dflt_dat : pulse request (merged while pending); code sampled at grant
//   host_req/dat/ack    : host write, req level held until the one-cycle ack
//   host_ovr            : while high, loop grants are acked and discarded
//   loop_req/dat/ack    : disciplining-loop write, same handshake as the host
//   sclk, mosi, sync_n  : AD5662 serial pins
//   busy                : high from grant until the inter-frame gap has elapsed
//   dac_cur             : last code completely shifted into the DAC
//   dbg_state           : overall state_t encoding (IDLE/LOAD/SYNC/SHIFT/GAP)
// Handshake: a requester raises req with dat stable and keeps both until it sees
// ack; ack is high for exactly the LOAD cycle and dat is captured at the end of it.
// req still high after the ack cycle is taken as a fresh request.
// Priority at each IDLE decision: pending default load, then host, then loop.
// Optional build macro DAC_ARB_DEDUP_EN: a granted code equal to dac_cur is acked
// but not sent.
module tcxo_dac_arbiter
  import dac_arb_pkg::*;
#(
  parameter int SCLK_DIV = 4,
  parameter int MIN_GAP  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dflt_load,
  input  logic [15:0] dflt_dat,
  input  logic        host_req,
  input  logic [15:0] host_dat,
  output logic        host_ack,
  input  logic        host_ovr,
  input  logic        loop_req,
  input  logic [15:0] loop_dat,
  output logic        loop_ack,
  output logic        sclk,
  output logic        mosi,
  output logic        sync_n,
  output logic        busy,
  output logic [15:0] dac_cur,
  output logic [2:0]  dbg_state
);

  state_t      state, state_n;
  req_idx_t    win_q, win_d;
  logic        dflt_pend;
  logic        host_ack_q, loop_ack_q, busy_q;
  logic [15:0] dac_cur_q, code_q, code_sel;
  logic        any_req, grant, drop_loop, dup_code, send;
  logic        tx_start, tx_done, tx_shifted;
  logic [2:0]  tx_state;

  always_comb begin
    any_req = dflt_pend | host_req | loop_req;
    if (dflt_pend)     win_d = DFLT;
    else if (host_req) win_d = HOST;
    else               win_d = LOOP;

    case (win_q)
      DFLT:    code_sel = dflt_dat;
      HOST:    code_sel = host_dat;
      LOOP:    code_sel = loop_dat;
      default: code_sel = DAC_MIDSCALE;
    endcase

    drop_loop = (win_q == LOOP) && host_ovr;
`ifdef DAC_ARB_DEDUP_EN
    // dac_cur cannot move here: LOAD is only reachable after the previous GAP
    dup_code = (code_sel == dac_cur_q);
`else
    dup_code = 1'b0;
`endif
    send     = !drop_loop && !dup_code;
    grant    = (state == IDLE) && any_req;
    tx_start = (state == LOAD) && send;

    state_n = state;
    case (state)
      IDLE:  if (any_req) state_n = LOAD;
      LOAD:  state_n = send ? SYNC : IDLE;
      // the shifter sequences SYNC/SHIFT/GAP; the arbiter parks in SYNC until done
      SYNC, SHIFT, GAP: if (tx_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      win_q      <= DFLT;
      dflt_pend  <= 1'b0;
      host_ack_q <= 1'b0;
      loop_ack_q <= 1'b0;
      busy_q     <= 1'b0;
      dac_cur_q  <= DAC_MIDSCALE;
      code_q     <= DAC_MIDSCALE;
    end else begin
      state      <= state_n;
      host_ack_q <= grant && (win_d == HOST);
      loop_ack_q <= grant && (win_d == LOOP);
      busy_q     <= (state_n != IDLE);
      // a pulse coinciding with the grant of the previous one is a new request
      dflt_pend  <= (dflt_pend && !(grant && (win_d == DFLT))) || dflt_load;
      if (grant)      win_q     <= win_d;
      if (tx_start)   code_q    <= code_sel;
      if (tx_shifted) dac_cur_q <= code_q;
    end
  end

  dac_spi_frame_tx #(
    .SCLK_DIV (SCLK_DIV),
    .MIN_GAP  (MIN_GAP)
  ) u_tx (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (tx_start),
    .dat       (code_sel),
    .done      (tx_done),
    .shifted   (tx_shifted),
    .sclk      (sclk),
    .mosi      (mosi),
    .sync_n    (sync_n),
    .state_dbg (tx_state)
  );

  assign host_ack  = host_ack_q;
  assign loop_ack  = loop_ack_q;
  assign busy      = busy_q;
  assign dac_cur   = dac_cur_q;
  assign dbg_state = (state == IDLE || state == LOAD) ? state : tx_state;

endmodule

// File: tb/tb_tcxo_dac_arbiter.sv
// tb_tcxo_dac_arbiter: self-checking bench for tcxo_dac_arbiter (defaults
// SCLK_DIV=4, MIN_GAP=8). Expected frames are queued when requests are driven
// and compared when the serial monitor sees sync_n rise.
module tb_tcxo_dac_arbiter;

`ifdef DAC_ARB_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic        clk, reset_n;
  logic        dflt_load, host_req, host_ovr, loop_req;
  logic [15:0] dflt_dat, host_dat, loop_dat;
  logic        host_ack, loop_ack, sclk, mosi, sync_n, busy;
  logic [15:0] dac_cur;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [23:0] exp_q[$];
  logic [15:0] exp_cur;

  // monitor state
  logic [23:0] mon_sh;
  int          mon_bits, mon_low;
  logic        prev_sclk, prev_sync;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  tcxo_dac_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .dflt_load (dflt_load),
    .dflt_dat  (dflt_dat),
    .host_req  (host_req),
    .host_dat  (host_dat),
    .host_ack  (host_ack),
    .host_ovr  (host_ovr),
    .loop_req  (loop_req),
    .loop_dat  (loop_dat),
    .loop_ack  (loop_ack),
    .sclk      (sclk),
    .mosi      (mosi),
    .sync_n    (sync_n),
    .busy      (busy),
    .dac_cur   (dac_cur),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / serial monitor ----------------
  always @(negedge clk) begin
    if (!reset_n) begin
      mon_bits = 0;
      mon_low  = 0;
      mon_sh   = '0;
    end else if (!sync_n) begin
      mon_low++;
      if (prev_sclk && !sclk) begin
        mon_sh = {mon_sh[22:0], mosi};
        mon_bits++;
      end
    end else if (!prev_sync) begin
      check("frame_bits", mon_bits, 24);
      check("sync_low_cycles", mon_low, 196);
      if (exp_q.size() == 0) begin
        check("frame_unexpected", mon_sh, 24'hxxxxxx);
      end else begin
        check("frame_data", mon_sh, exp_q.pop_front());
      end
      mon_bits = 0;
      mon_low  = 0;
    end
    prev_sclk = sclk;
    prev_sync = sync_n;
  end

  // ---------------- driver tasks ----------------
  // Runs the 205 cycles after an ack cycle (k=0) for a frame carrying dat.
  task automatic frame_after_ack(input logic [15:0] dat);
    for (int k = 1; k <= 205; k++) begin
      @(negedge clk);
      if (k == 1)   check("sync_fall", sync_n, 1'b0);
      if (k == 196) check("cur_before", dac_cur, exp_cur);
      if (k == 197) begin
        exp_cur = dat;
        check("cur_after", dac_cur, exp_cur);
      end
      if (k == 204) check("busy_gap", busy, 1'b1);
      if (k == 205) check("busy_done", busy, 1'b0);
    end
  endtask

  // Waits for an ack (bounded); returns the number of negedges taken.
  task automatic wait_ack(input bit is_host, output int lat);
    bit got;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 500) begin
      @(negedge clk);
      lat++;
      got = is_host ? host_ack : loop_ack;
    end
  endtask

  task automatic do_write(input bit is_host, input logic [15:0] dat, input bit exp_frame);
    int lat;
    @(negedge clk);
    if (is_host) begin host_dat = dat; host_req = 1'b1; end
    else         begin loop_dat = dat; loop_req = 1'b1; end
    if (exp_frame) exp_q.push_back({8'h00, dat});
    wait_ack(is_host, lat);
    check(is_host ? "host_ack_lat" : "loop_ack_lat", lat, 1);
    host_req = 1'b0;
    loop_req = 1'b0;
    if (exp_frame) begin
      frame_after_ack(dat);
    end else begin
      @(negedge clk);
      check("nofr_busy", busy, 1'b0);
      check("nofr_sync", sync_n, 1'b1);
      check("nofr_cur", dac_cur, exp_cur);
      repeat (6) @(negedge clk);
      check("nofr_sync_later", sync_n, 1'b1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    reset_n = 1'b0; dflt_load = 1'b0; host_req = 1'b0; host_ovr = 1'b0; loop_req = 1'b0;
    dflt_dat = '0; host_dat = '0; loop_dat = '0;
    prev_sclk = 1'b1; prev_sync = 1'b1;
    exp_cur = 16'd32767;
    repeat (3) @(negedge clk);
    check("rst_sync_n", sync_n, 1'b1);
    check("rst_sclk", sclk, 1'b1);
    check("rst_mosi", mosi, 1'b0);
    check("rst_acks", {host_ack, loop_ack}, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_dac_cur", dac_cur, 16'd32767);
    check("rst_state", dbg_state, 3'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single loop write
    do_write(1'b0, 16'hA5C3, 1'b1);

    // 2: host and loop together -> host first, loop acked at cycle 206
    @(negedge clk);
    host_dat = 16'h1234; loop_dat = 16'hBEEF;
    host_req = 1'b1; loop_req = 1'b1;
    exp_q.push_back({8'h00, 16'h1234});
    exp_q.push_back({8'h00, 16'hBEEF});
    wait_ack(1'b1, lat);
    check("both_host_lat", lat, 1);
    check("both_loop_held", loop_ack, 1'b0);
    host_req = 1'b0;
    frame_after_ack(16'h1234);
    wait_ack(1'b0, lat);
    check("loop_after_host", 205 + lat, 206);
    loop_req = 1'b0;
    frame_after_ack(16'hBEEF);

    // 3: merged default loads during a host frame, served before a pending loop
    @(negedge clk);
    host_dat = 16'h0F0F; host_req = 1'b1;
    exp_q.push_back({8'h00, 16'h0F0F});
    wait_ack(1'b1, lat);
    check("h3_lat", lat, 1);
    host_req = 1'b0;
    for (int k = 1; k <= 206; k++) begin
      @(negedge clk);
      dflt_load = 1'b0;
      if (k == 10)  begin dflt_dat = 16'h1111; dflt_load = 1'b1; exp_q.push_back({8'h00, 16'h3333}); end
      if (k == 50)  begin dflt_dat = 16'h2222; dflt_load = 1'b1; end
      if (k == 100) begin dflt_dat = 16'h3333; dflt_load = 1'b1; end
      if (k == 120) begin
        loop_dat = 16'h7777; loop_req = 1'b1;
        exp_q.push_back({8'h00, 16'h7777});
      end
      if (k == 197) begin
        exp_cur = 16'h0F0F;
        check("h3_cur", dac_cur, exp_cur);
      end
      if (k == 206) begin
        check("dflt_no_ack", {host_ack, loop_ack}, 2'b00);
        check("dflt_busy", busy, 1'b1);
      end
    end
    wait_ack(1'b0, lat);
    check("loop_after_dflt", 206 + lat, 412);
    exp_cur = 16'h3333;
    check("dflt_cur", dac_cur, exp_cur);
    loop_req = 1'b0;
    frame_after_ack(16'h7777);

    // 4: loop under host override -> acked, discarded
    host_ovr = 1'b1;
    do_write(1'b0, 16'h0400, 1'b0);
    host_ovr = 1'b0;

    // 5: reset in the middle of a frame
    @(negedge clk);
    loop_dat = 16'h1357; loop_req = 1'b1;
    wait_ack(1'b0, lat);
    check("r5_lat", lat, 1);
    loop_req = 1'b0;
    lat = 0;
    while (mon_bits < 10 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check("r5_reached_bit10", mon_bits, 10);
    reset_n = 1'b0;
    #1;
    check("r5_sync_n", sync_n, 1'b1);
    check("r5_sclk", sclk, 1'b1);
    check("r5_busy", busy, 1'b0);
    exp_cur = 16'd32767;
    check("r5_dac_cur", dac_cur, exp_cur);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    do_write(1'b0, 16'h2468, 1'b1);

    // 6: repeated code (dropped only in the dedup build)
    do_write(1'b0, 16'h8000, 1'b1);
    do_write(1'b0, 16'h8000, !DEDUP);

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
